// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: boot-loadable instruction memory with registered, fault-checked fetches.
module instr_mem_loadable #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h00400000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ReadMem,
    input  logic [ADDR_W-1:0]          Dir_Instru,
    output logic [DATA_W-1:0]          Dato_Instru,
    output logic                       instr_valid,
    output logic                       instr_fault,
    input  logic                       load_we,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       load_done,
    output logic [$clog2(DEPTH+1)-1:0] load_count,
    output logic                       load_full,
    output logic                       running
);
    localparam int BYTES = DATA_W / 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic {LOAD, RUN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       load_count_q, load_count_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d, fault_q, fault_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   off, idx;
    logic                wr, fetch, hit;

    always_comb begin
        off          = Dir_Instru - BASE_ADDR;
        idx          = off / ADDR_W'(BYTES);
        // the >= BASE_ADDR term stops addresses below base from wrapping into range
        hit          = off % ADDR_W'(BYTES) == '0 && Dir_Instru >= BASE_ADDR &&
                       idx < ADDR_W'(DEPTH) && idx < ADDR_W'(load_count_q);
        wr           = state_q == LOAD && load_we && !load_full;
        fetch        = state_q == RUN && !ReadMem;
        load_count_d = load_count_q + CW'(wr);
        state_d      = (state_q == LOAD && load_done) ? RUN : state_q;
        valid_d      = fetch;
        fault_d      = fetch && !hit;
        data_d       = (fetch && hit) ? mem[idx[IW-1:0]] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            load_count_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
        end
    end

    // contents survive reset; they become unreachable because the count clears
    always_ff @(posedge clk) begin
        if (wr) mem[load_count_q[IW-1:0]] <= load_data;
    end

    assign Dato_Instru = data_q;
    assign instr_valid = valid_q;
    assign instr_fault = fault_q;
    assign load_count  = load_count_q;
    assign load_full   = load_count_q == CW'(DEPTH);
    assign running     = state_q == RUN;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: directed and randomized checks against an address-arithmetic reference model.
module tb_instr_mem_loadable;
    localparam logic [31:0] BASE = 32'h00400000;
    logic        clk = 0, rst = 1, ReadMem = 1, load_we = 0, load_done = 0;
    logic [31:0] Dir_Instru = 0, load_data = 0, Dato_Instru;
    logic        instr_valid, instr_fault, load_full, running;
    logic [4:0]  load_count;
    int          total = 0, bad = 0;
    logic [31:0] mdl [16];
    int          cnt = 0;
    bit          run = 0, e_valid = 0, e_fault = 0;
    logic [31:0] e_data = 0;

    always #5 clk = ~clk;

    instr_mem_loadable dut (
        .clk(clk), .rst(rst), .ReadMem(ReadMem), .Dir_Instru(Dir_Instru),
        .Dato_Instru(Dato_Instru), .instr_valid(instr_valid), .instr_fault(instr_fault),
        .load_we(load_we), .load_data(load_data), .load_done(load_done),
        .load_count(load_count), .load_full(load_full), .running(running)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, Dato_Instru, e_data);
        check({tag, ".valid"}, instr_valid, e_valid);
        check({tag, ".fault"}, instr_fault, e_fault);
        check({tag, ".count"}, load_count, cnt);
        check({tag, ".full"}, load_full, cnt == 16);
        check({tag, ".running"}, running, run);
    endtask

    // one clock: drive inputs, advance the model across the edge, compare after it
    task automatic cyc(input bit rm, input logic [31:0] a, input bit we, input logic [31:0] d, input bit done);
        longint off;
        ReadMem = rm; Dir_Instru = a; load_we = we; load_data = d; load_done = done;
        e_valid = 0; e_fault = 0; e_data = 0;
        if (!run) begin
            if (we && cnt < 16) begin
                mdl[cnt] = d;
                cnt++;
            end
            if (done) run = 1;
        end else if (!rm) begin
            e_valid = 1;
            off = longint'(a) - longint'(BASE);
            if (off < 0 || off % 4 != 0 || off / 4 >= 16 || off / 4 >= cnt) e_fault = 1;
            else e_data = mdl[off / 4];
        end
        @(posedge clk); #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        #($urandom_range(1, 3));
        rst = 1;
        #1;
        check("async.data", Dato_Instru, 0);
        check("async.valid", instr_valid, 0);
        check("async.fault", instr_fault, 0);
        check("async.count", load_count, 0);
        check("async.running", running, 0);
        ReadMem = 1; load_we = 0; load_done = 0;
        @(posedge clk); #1;
        rst = 0;
        cnt = 0; run = 0; e_valid = 0; e_fault = 0; e_data = 0;
        check_all("post_rst");
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return BASE + 4 * $urandom_range(0, 17);
            1: return BASE + $urandom_range(0, 80);
            2: return BASE - 4 * $urandom_range(1, 4);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        @(posedge clk); #1;
        rst = 0;
        check_all("reset");
        cyc(0, BASE, 0, 0, 0);

        cyc(1, 0, 1, 32'h00000100, 0);
        cyc(1, 0, 1, 32'h01000110, 0);
        cyc(1, 0, 1, 32'h00100100, 0);
        cyc(1, 0, 0, 0, 1);
        check("tp.count3", load_count, 3);
        cyc(0, BASE + 4, 0, 0, 0);
        check("tp.word1", Dato_Instru, 32'h01000110);
        foreach (mdl[i]) if (i == 0) begin
            cyc(0, 32'h00400002, 0, 0, 0);
            cyc(0, 32'h003FFFFC, 0, 0, 0);
            cyc(0, 32'h00400040, 0, 0, 0);
            cyc(0, 32'h0040000C, 0, 0, 0);
            check("tp.unloaded_fault", instr_fault, 1);
        end

        do_reset();
        for (int i = 0; i < 18; i++) cyc(1, 0, 1, $urandom, 0);
        check("tp.full", load_full, 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(0, BASE + 4 * i, 0, 0, 0);

        do_reset();
        cyc(1, 0, 1, 32'hCAFEF00D, 1);
        cyc(1, 0, 1, 32'h12345678, 0);
        check("tp.count_run", load_count, 1);
        cyc(0, BASE, 0, 0, 0);
        check("tp.word0", Dato_Instru, 32'hCAFEF00D);
        cyc(0, BASE + 4, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, $urandom, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, BASE, 0, 0, 0);
        cyc(1, BASE + 8, 0, 0, 0);
        cyc(0, BASE + 8, 0, 0, 0);
        do_reset();

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(0, 18);
            for (int i = 0; i < n; i++) cyc($urandom_range(0, 1), rand_addr(), $urandom_range(0, 3) != 0, $urandom, 0);
            cyc(1, 0, $urandom_range(0, 1), $urandom, 1);
            for (int i = 0; i < 40; i++)
                cyc($urandom_range(0, 3) == 0, rand_addr(), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised instruction memory: the next generation of the fixed-content, PC-addressed instruction ROM. Word depth, data width, address width and base address are parameters. Contents are boot-loaded through a sequential load port, then the block switches to run mode and serves registered fetches with an active-low read enable. It sits between the PC/fetch stage and the decode stage. Adds range, alignment and unloaded-word fault reporting.

Parameters:
DATA_W, 32, instruction width in bits; a multiple of 8.
ADDR_W, 32, fetch address width.
DEPTH, 16, number of instruction words; ≥2.
BASE_ADDR, 32'h00400000, byte address of word 0; aligned to DATA_W/8.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
ReadMem  in  1  fetch enable, active-low.
Dir_Instru  in  ADDR_W  fetch byte address (PC).
Dato_Instru  out  DATA_W  fetched instruction, registered.
instr_valid  out  1  Dato_Instru holds a fetch result this cycle.
instr_fault  out  1  the fetch was misaligned, out of range, or hit an unloaded word.
load_we  in  1  write load_data into the next free word.
load_data  in  DATA_W  boot-load word.
load_done  in  1  end of load phase; enter RUN.
load_count  out  $clog2(DEPTH+1)  number of words loaded.
load_full  out  1  load_count == DEPTH.
running  out  1  state == RUN.

Behaviour:
- Reset (async, rst=1):
  - Dato_Instru=0, instr_valid=0, instr_fault=0, load_count=0, load_full=0, running=0, state=LOAD.
  - The memory array is not cleared. Its old contents are unreachable because load_count=0.
- States: LOAD → RUN on load_done. RUN is left only by rst. No other transitions.
- LOAD:
  - load_we=1 and !load_full: mem[load_count] <= load_data and load_count increments.
  - load_full asserts combinationally when load_count == DEPTH.
  - load_we while full: ignored, no wrap, count holds.
  - Fetch outputs stay 0 regardless of ReadMem.
  - load_done=1: running=1 from the next edge.
  - load_we and load_done in the same cycle: the write is accepted, then the block enters RUN.
- RUN:
  - load_we and load_done are ignored; memory is read-only.
  - Each edge with ReadMem=0: instr_valid<=1.
    - Valid address: Dato_Instru<=mem[idx], instr_fault<=0.
    - Invalid address: Dato_Instru<=0, instr_fault<=1.
  - Each edge with ReadMem=1: Dato_Instru<=0, instr_valid<=0, instr_fault<=0.
  - Latency is 1 cycle from address to data. Back-to-back fetches run every cycle.
- Address decode:
  - off = Dir_Instru − BASE_ADDR, computed at ADDR_W bits unsigned.
  - idx = off / (DATA_W/8).
  - The address is valid iff all of the following hold:
    - off mod (DATA_W/8) == 0;
    - Dir_Instru ≥ BASE_ADDR;
    - idx < DEPTH;
    - idx < load_count.
  - An address below BASE_ADDR must fault; unsigned wrap must not alias it into range.
- Reset mid-fetch or mid-load: outputs clear immediately, without waiting for clk. A partial load is discarded by the count reset.

Test Plan:
- Reset with rst=1 at arbitrary times, then release → all outputs 0, running=0, state LOAD; a fetch with ReadMem=0 at 0x00400000 gives instr_valid=0.
- Load 3 words (0x00000100, 0x01000110, 0x00100100), then load_done → load_count=3, running=1 one cycle after load_done; fetch 0x00400004 → one cycle later Dato_Instru=0x01000110, instr_valid=1, instr_fault=0.
- Fault cases in RUN after loading 3 words, each giving Dato_Instru=0, instr_valid=1, instr_fault=1:
  - 0x00400002 (misaligned);
  - 0x003FFFFC (below base);
  - 0x00400040 (idx ≥ DEPTH);
  - 0x0040000C (unloaded, idx 3).
- Load DEPTH+2 words → load_full=1 at count 16; the last 2 writes are ignored; mem[0] is unchanged (no wrap).
- load_we and load_done in the same cycle at count 0 → load_count=1, running=1. A later load_we in RUN does not change load_count or memory.
- ReadMem toggles 0,1,0 while fetching 0x00400000 and 0x00400008 → valid pattern 1,0,1 with data mem[0], 0, mem[2]. Assert rst mid-stream → outputs 0 before the next edge.
